regfile_wb_arbiter: RTL

//  Shares the single register-file write port between NUM_REQ write-back sources (ALU, load unit, multi-cycle unit).

---
 rtl/rf_pkg.sv | 11 +
 rtl/rr_arbiter.sv | 28 ++
 rtl/regfile_wb_arbiter.sv | 129 ++++++++++++
 3 files changed

// File: rtl/rf_pkg.sv
// Shared register-file constants and types for the write-back path.
package rf_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 1 << REG_ADDR_W;

  typedef logic [REG_ADDR_W-1:0] reg_idx_t;
  typedef logic [XLEN-1:0]       xlen_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: the search starts at ptr, the first active request wins,
// and the next pointer is the slot after the winner (ptr is unchanged if nothing wins).
module rr_arbiter #(
  parameter int N     = 2,
  parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [PTR_W-1:0] next_ptr
);

  // Find the first active request at or after ptr, wrapping around
  always_comb begin
    // NOTE: every output gets a default before the loop; a path that leaves one unassigned infers a latch.
    grant    = '0;
    next_ptr = ptr;
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = (int'(ptr) + k) % N;
      if (grant == '0 && req[idx]) begin
        grant[idx] = 1'b1;
        next_ptr   = PTR_W'((idx + 1) % N);
      end
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Register-file write-back arbiter: NUM_REQ sources share one regfile write
// port through a round-robin grant and a single registered write stage.
// Optional busy scoreboard enabled by defining RF_WB_SCOREBOARD_EN.
module regfile_wb_arbiter
  import rf_pkg::*;
#(
  parameter int NUM_REQ    = 2,
  parameter int XLEN       = rf_pkg::XLEN,
  parameter int REG_ADDR_W = rf_pkg::REG_ADDR_W
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          wb_stall,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*REG_ADDR_W-1:0] req_rd,
  input  logic [NUM_REQ*XLEN-1:0]       req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          rf_we,
  output logic [REG_ADDR_W-1:0]         rf_rd,
  output logic [XLEN-1:0]               rf_wdata,
  input  logic                          issue_valid,
  input  logic [REG_ADDR_W-1:0]         issue_rd,
  input  logic [REG_ADDR_W-1:0]         rs1_addr,
  input  logic [REG_ADDR_W-1:0]         rs2_addr,
  output logic                          rs1_busy,
  output logic                          rs2_busy
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PTR_W-1:0]      rr_ptr;
  logic [PTR_W-1:0]      rr_ptr_next;
  logic [NUM_REQ-1:0]    req_eligible;
  logic [NUM_REQ-1:0]    grant;
  logic                  grant_any;
  logic [REG_ADDR_W-1:0] sel_rd;
  logic [XLEN-1:0]       sel_data;

  // Nothing is eligible while frozen or held in reset
  assign req_eligible = (rst || wb_stall) ? '0 : req_valid;

  rr_arbiter #(
    .N     (NUM_REQ),
    .PTR_W (PTR_W)
  ) u_rr_arbiter (
    .req      (req_eligible),
    .ptr      (rr_ptr),
    .grant    (grant),
    .next_ptr (rr_ptr_next)
  );

  assign req_ready = grant;
  assign grant_any = |grant;

  // Route the granted source's destination and data to the write stage
  always_comb begin
    sel_rd   = '0;
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_rd   = req_rd[i*REG_ADDR_W +: REG_ADDR_W];
        sel_data = req_data[i*XLEN +: XLEN];
      end
    end
  end

  // Advance the round-robin pointer only on a grant
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst)            rr_ptr <= '0;
    else if (grant_any) rr_ptr <= rr_ptr_next;
  end

  // Registered write stage; x0 transfers are accepted but never written
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_we    <= 1'b0;
      rf_rd    <= '0;
      rf_wdata <= '0;
    end else begin
      rf_we <= grant_any && (sel_rd != '0);
      if (grant_any) begin
        rf_rd    <= sel_rd;
        rf_wdata <= sel_data;
      end
    end
  end

`ifdef RF_WB_SCOREBOARD_EN
  localparam int NUM_REGS = 1 << REG_ADDR_W;

  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_next;
  logic                clr_hit;

  // A granted transfer to the same index as an issue on this edge
  assign clr_hit = grant_any && (sel_rd == issue_rd);

  // Clear on granted write-back, then set on issue so a new writer wins
  always_comb begin
    busy_next = busy_q;
    if (grant_any && sel_rd != '0) busy_next[sel_rd] = 1'b0;
    if (issue_valid && issue_rd != '0) busy_next[issue_rd] = 1'b1;
  end

  // Busy bit storage
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: this is a small flop vector, not a RAM, so it takes the reset like any other state.
    if (rst) busy_q <= '0;
    else     busy_q <= busy_next;
  end

  // Issuing to an index that still has an outstanding writer is illegal
  always_ff @(posedge clk) begin
    if (!rst && issue_valid && issue_rd != '0)
      assert (!busy_q[issue_rd] || clr_hit);
  end

  assign rs1_busy = (rs1_addr != '0) && busy_q[rs1_addr];
  assign rs2_busy = (rs2_addr != '0) && busy_q[rs2_addr];
`else
  logic unused_issue;
  assign unused_issue = ^{issue_valid, issue_rd, rs1_addr, rs2_addr};

  assign rs1_busy = 1'b0;
  assign rs2_busy = 1'b0;
`endif

endmodule
